mem_stall_ctrl: RTL and testbench
=================================

# mem_stall_ctrl

Memory-stage access controller sitting between the M-stage pipeline signals and a multi-cycle data memory. It accepts one load or store from the pipeline, drives a single-cycle request to memory, waits for the memory acknowledge, and returns load data. It is the source of `dstall`: it holds the pipeline frozen while an access is outstanding and releases it for exactly one cycle when the result is ready.

## Interface
- `TIMEOUT`, 255: cycles to wait for `memAck` before aborting; used only when the timeout feature is compiled in.
- `clk` in 1: the block's single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `readEnM` in 1: load request from the M stage.
- `memWrtM` in 1: store request from the M stage.
- `addrM` in 16: byte address of the access.
- `wrtDataM` in 16: store data.
- `memAck` in 1: memory completed the access.
- `memRData` in 16: load data; valid only when `memAck` is high.
- `memReq` out 1: one-cycle request pulse to memory.
- `memWr` out 1: qualifies `memReq` as a write.
- `memAddr` out 16: latched address.
- `memWData` out 16: latched store data.
- `dstall` out 1: freezes the pipeline flops.
- `dataOutM` out 16: load result.
- `done` out 1: access-complete pulse.
- `err` out 1: illegal access or timeout pulse.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - A legal request (exactly one of `readEnM` / `memWrtM`, `addrM[0]`=0) latches address, data and direction, and moves to REQ.
  - `dstall` goes high combinationally in that same cycle.
- **Illegal request** (both enables high, or `addrM[0]`=1)
  - `err` pulses high for one cycle, registered.
  - No memory request, no stall, FSM stays in IDLE.
- **REQ**
  - `memReq`=1 for exactly one cycle.
  - `memWr` equals the latched direction.
  - If `memAck` is already high in REQ, go to DONE. Otherwise go to WAIT.
- **WAIT**
  - Stay until `memAck`=1, then go to DONE.
  - On an ack for a load, capture `memRData` into `dataOutM`.
- **DONE**
  - `done`=1 and `dstall`=0 for one cycle; the pipeline advances at the end of this cycle.
  - The M-stage request inputs still hold the same instruction here, so they are ignored.
  - Next state is always IDLE.
- **Stores:** `dataOutM` keeps its previous value.
- **Held outputs:** `memAddr` and `memWData` stay stable from REQ through DONE and keep their value while idle.
- **Ignored acks:** `memAck` in IDLE or DONE is ignored, including a stale ack arriving after reset.

## Timing
- **Reset values:** every output is 0 and the FSM is in IDLE. Reset takes effect immediately, including mid-access. Any outstanding memory transaction is abandoned.
- **Baseline access:** request seen in cycle 0, `memReq` in cycle 1, `memAck` in cycle 1+k (k≥0), `done` in cycle 2+k.
- **Stall length:** `dstall` is high in cycles 0 through 1+k, i.e. 2+k stall cycles.
- **Back-to-back accesses:** a new request can be accepted in the IDLE cycle right after DONE, so accesses are separated by a minimum of 3 cycles.
- **Pulse widths:** `done` and `err` are single-cycle pulses and are never high together.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - A counter clears on entering REQ and counts each cycle spent in REQ/WAIT without `memAck`.
  - When the count reaches `TIMEOUT`, the FSM goes to DONE with `err`=1 and `dataOutM`=0; `done` is 0 in that cycle.
  - If `memAck` arrives in the same cycle the count reaches `TIMEOUT`, the ack wins and completes the access normally.
- **`MEM_TIMEOUT_EN` undefined:** no counter is built; WAIT waits indefinitely and `err` comes only from illegal requests.

## Structure
- **Shared package `mem_ctrl_pkg`:** the FSM state enum, the data/address width constant (16), and the default `TIMEOUT`.
- **Sub-module `mem_wdog_cnt`:**
  - Holds the timeout counter, with clear, enable and an `expired` output.
  - Instantiated only under `MEM_TIMEOUT_EN`.
- **Everything else** stays in one module: the FSM and the address/data/result registers.

## Test plan
- **Load, ack after 3 cycles:** `readEnM`=1, `addrM`=0x0010, `memRData`=0xBEEF.
  - `memReq` in cycle 1 with `memWr`=0.
  - `dstall` high in cycles 0–4.
  - `done` in cycle 5 with `dataOutM`=0xBEEF.
- **Store, immediate ack in REQ:** `memWrtM`=1, `addrM`=0x0020, `wrtDataM`=0x1234.
  - `memWr`=1, `memWData`=0x1234, `memAddr`=0x0020.
  - `done` in cycle 2, `dataOutM` unchanged.
- **Illegal requests:**
  - `addrM`=0x0021 with a load: `err` pulses in cycle 1, with no `memReq` and no `dstall`.
  - Both enables high: same response.
- **Reset mid-access:** pull `rst_n` low during WAIT, then release.
  - All outputs read 0 and the FSM is in IDLE.
  - A late `memAck` produces no `done`.
- **Timeout (with `MEM_TIMEOUT_EN`, `TIMEOUT`=4):** load with no ack.
  - `err`=1 and `dataOutM`=0 in the DONE cycle.
  - `dstall` drops in that same cycle.
  - Without the macro, `dstall` stays high for 100 cycles.
- **Back-to-back loads (ack k=0):** `done` pulses at cycles 2 and 5, and the second `memReq` occurs at cycle 4.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the M-stage memory access controller:
// FSM state encoding, data/address width and the default ack timeout.
package mem_ctrl_pkg;

    localparam int DATA_W          = 16;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } memStateE;

endpackage

// File: rtl/mem_wdog_cnt.sv
// Watchdog counter for outstanding memory accesses. Cleared when an access
// is accepted, advanced for every in-flight cycle without an ack. 'expired'
// flags the cycle whose missing ack brings the count up to TIMEOUT.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_wdog_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] countReg;

    // Count no-ack cycles; the FSM leaves on expiry, so no wrap handling needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (enable && !expired) begin
            countReg <= countReg + 1'b1;
        end
    end

    assign expired = enable && (countReg == LAST);

endmodule

// File: rtl/mem_stall_ctrl.sv
// M-stage memory access controller: accepts one load/store, issues a
// single-cycle request to a multi-cycle memory, waits for the ack and
// returns load data, holding dstall high while the access is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses whose ack does
// not arrive within TIMEOUT cycles.
module mem_stall_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              readEnM,
    input  logic              memWrtM,
    input  logic [DATA_W-1:0] addrM,
    input  logic [DATA_W-1:0] wrtDataM,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic              memReq,
    output logic              memWr,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    output logic              dstall,
    output logic [DATA_W-1:0] dataOutM,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REQ  = ST_REQ;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]        stateReg, stateNext;
    logic              wrReg;
    logic [DATA_W-1:0] addrReg, wDataReg, dataOutReg;
    logic              errReg;      // registered illegal-request pulse
    logic              timedOutReg; // DONE was reached by timeout

    logic isIdle, isReq, isWait, isDone, inFlight;
    logic legalReq, illegalReq, accept, ackSeen, timedOut, wdogExpired;

    assign isIdle   = (stateReg == IDLE);
    assign isReq    = (stateReg == REQ);
    assign isWait   = (stateReg == WAIT);
    assign isDone   = (stateReg == DONE);
    assign inFlight = isReq | isWait;

    // Exactly one enable and a halfword-aligned address
    assign legalReq   = (readEnM ^ memWrtM) & ~addrM[0];
    assign illegalReq = (readEnM | memWrtM) & ~legalReq;
    assign accept     = isIdle & legalReq;
    assign ackSeen    = inFlight & memAck;
    // An ack in the expiry cycle wins over the timeout
    assign timedOut   = inFlight & ~memAck & wdogExpired;

`ifdef MEM_TIMEOUT_EN
    mem_wdog_cnt #(
        .TIMEOUT (TIMEOUT)
    ) uWdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (inFlight & ~memAck),
        .expired (wdogExpired)
    );
`else
    // No watchdog: an outstanding access never expires
    assign wdogExpired = (TIMEOUT < 0);
`endif

    // Next-state logic for the access sequence IDLE -> REQ -> [WAIT] -> DONE
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:     if (legalReq) stateNext = REQ;
            REQ,
            WAIT:     if (memAck || timedOut) stateNext = DONE;
                      else                    stateNext = WAIT;
            DONE:     stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // State, latched access fields, load result and pulse flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            wrReg       <= 1'b0;
            addrReg     <= '0;
            wDataReg    <= '0;
            dataOutReg  <= '0;
            errReg      <= 1'b0;
            timedOutReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            errReg      <= isIdle & illegalReq;
            timedOutReg <= timedOut;
            if (accept) begin
                wrReg    <= memWrtM;
                addrReg  <= addrM;
                wDataReg <= wrtDataM;
            end
            if (ackSeen && !wrReg) begin
                dataOutReg <= memRData;
            end else if (timedOut) begin
                dataOutReg <= '0;
            end
        end
    end

    assign memReq   = isReq;
    assign memWr    = isReq & wrReg;
    assign memAddr  = addrReg;
    assign memWData = wDataReg;
    assign dataOutM = dataOutReg;
    // Stall starts combinationally on acceptance and releases in DONE
    assign dstall   = accept | inFlight;
    assign done     = isDone & ~timedOutReg;
    assign err      = errReg | (isDone & timedOutReg);

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: directed vector table, hand-built
// reset/stall sequences and randomized accesses checked against a
// transaction-level timeline model (stall 0..1+k, request at 1, done at 2+k).
module tb_mem_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        readEnM = 1'b0, memWrtM = 1'b0, memAck = 1'b0;
    logic [15:0] addrM = '0, wrtDataM = '0, memRData = '0;
    logic        memReq, memWr, dstall, done, err;
    logic [15:0] memAddr, memWData, dataOutM;

    int errors = 0;
    int checks = 0;
    int txnCount = 0;

    // Reference state: last load result and last accepted address/data
    logic [15:0] modelData = '0;
    logic [15:0] lastAddr = '0;
    logic [15:0] lastWData = '0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          k;
        int          gap;
        logic        expErr;
        logic [15:0] expData;
    } vecT;

    vecT vecs[8];

    mem_stall_ctrl #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .readEnM  (readEnM),
        .memWrtM  (memWrtM),
        .addrM    (addrM),
        .wrtDataM (wrtDataM),
        .memAck   (memAck),
        .memRData (memRData),
        .memReq   (memReq),
        .memWr    (memWr),
        .memAddr  (memAddr),
        .memWData (memWData),
        .dstall   (dstall),
        .dataOutM (dataOutM),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, " memReq"},   {15'd0, memReq},   16'h0);
        chk({tag, " memWr"},    {15'd0, memWr},    16'h0);
        chk({tag, " memAddr"},  memAddr,           16'h0);
        chk({tag, " memWData"}, memWData,          16'h0);
        chk({tag, " dstall"},   {15'd0, dstall},   16'h0);
        chk({tag, " dataOutM"}, dataOutM,          16'h0);
        chk({tag, " done"},     {15'd0, done},     16'h0);
        chk({tag, " err"},      {15'd0, err},      16'h0);
    endtask

    // Called at posedge+1; asserts reset mid-cycle, releases it on a negedge
    task automatic doReset(input string tag);
        readEnM = 1'b0;
        memWrtM = 1'b0;
        memAck  = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkAllZero(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        modelData = '0;
        lastAddr  = '0;
        lastWData = '0;
    endtask

    // Idle cycles with optional stray acks, which must be ignored
    task automatic idleCycles(input int n, input bit strayAck);
        for (int i = 0; i < n; i++) begin
            readEnM  = 1'b0;
            memWrtM  = 1'b0;
            memAck   = strayAck ? 1'($urandom_range(0, 1)) : 1'b0;
            memRData = 16'($urandom);
            @(negedge clk);
            chk("idle dstall", {15'd0, dstall}, 16'h0);
            chk("idle done",   {15'd0, done},   16'h0);
            chk("idle err",    {15'd0, err},    16'h0);
            chk("idle memReq", {15'd0, memReq}, 16'h0);
            chk("idle memAddr", memAddr, lastAddr);
            chk("idle dataOutM", dataOutM, modelData);
            nextCycle();
        end
        memAck = 1'b0;
    endtask

    // One access starting in cycle 0 (called at posedge+1 of that cycle)
    task automatic runAccess(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] rdata,
                             input int k, input logic expErr, input logic [15:0] expData);
        readEnM  = rd;
        memWrtM  = wr;
        addrM    = addr;
        wrtDataM = wdata;
        memAck   = 1'b0;
        memRData = 16'($urandom);
        @(negedge clk);
        chk("c0 dstall",  {15'd0, dstall}, {15'd0, !expErr});
        chk("c0 memReq",  {15'd0, memReq}, 16'h0);
        chk("c0 done",    {15'd0, done},   16'h0);
        chk("c0 err",     {15'd0, err},    16'h0);
        chk("c0 memAddr", memAddr, lastAddr);
        nextCycle();
        if (expErr) begin
            readEnM = 1'b0;
            memWrtM = 1'b0;
            @(negedge clk);
            chk("ill err",      {15'd0, err},    16'h1);
            chk("ill memReq",   {15'd0, memReq}, 16'h0);
            chk("ill dstall",   {15'd0, dstall}, 16'h0);
            chk("ill done",     {15'd0, done},   16'h0);
            chk("ill dataOutM", dataOutM, expData);
            nextCycle();
        end else begin
            lastAddr  = addr;
            lastWData = wdata;
            for (int c = 1; c <= 2 + k; c++) begin
                memAck   = (c == 1 + k);
                memRData = (c == 1 + k) ? rdata : 16'($urandom);
                @(negedge clk);
                chk("acc memReq",   {15'd0, memReq}, {15'd0, c == 1});
                if (c == 1) chk("acc memWr", {15'd0, memWr}, {15'd0, wr});
                chk("acc dstall",   {15'd0, dstall}, {15'd0, c <= 1 + k});
                chk("acc done",     {15'd0, done},   {15'd0, c == 2 + k});
                chk("acc err",      {15'd0, err},    16'h0);
                chk("acc memAddr",  memAddr,  addr);
                chk("acc memWData", memWData, wdata);
                if (c == 2 + k) chk("acc dataOutM", dataOutM, expData);
                nextCycle();
            end
        end
        modelData = expData;
        readEnM = 1'b0;
        memWrtM = 1'b0;
        memAck  = 1'b0;
        txnCount++;
        $display("txn %0d rd=%0b wr=%0b addr=%h wdata=%h k=%0d err=%0b dataOutM=%h",
                 txnCount, rd, wr, addr, wdata, k, err, dataOutM);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic        rdR, wrR, legalR;
        logic [15:0] addrR, wdataR, rdataR, expR;
        int          kindR, kR, gapR;
        int          stallHigh, doneSeen;

        //            rd    wr    addr      wdata     rdata     k  gap err   expData
        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3, 0, 1'b0, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 16'h7777, 0, 1, 1'b0, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'h0000, 0, 1, 1'b1, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b1, 16'h0030, 16'h5555, 16'h0000, 0, 0, 1'b1, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 1, 2, 1'b0, 16'h5A5A};
        vecs[5] = '{1'b0, 1'b1, 16'h0042, 16'hFFFF, 16'h1111, 2, 0, 1'b0, 16'h5A5A};
        vecs[6] = '{1'b1, 1'b0, 16'h0044, 16'h0000, 16'h0001, 0, 1, 1'b0, 16'h0001};
        vecs[7] = '{1'b1, 1'b0, 16'h0046, 16'h0000, 16'h8000, 0, 0, 1'b0, 16'h8000};

        // Reset with a stale ack present
        memAck = 1'b1;
        #12;
        checkAllZero("reset");
        rst_n = 1'b1;
        nextCycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stale ack done",   {15'd0, done},   16'h0);
            chk("stale ack dstall", {15'd0, dstall}, 16'h0);
            chk("stale ack memReq", {15'd0, memReq}, 16'h0);
            nextCycle();
        end
        memAck = 1'b0;

        // Directed vector table; vecs[6]/[7] form a back-to-back k=0 pair
        for (int v = 0; v < 8; v++) begin
            idleCycles(vecs[v].gap, 1'b0);
            runAccess(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                      vecs[v].rdata, vecs[v].k, vecs[v].expErr, vecs[v].expData);
        end

        // Reset in the middle of a load while waiting for the ack
        readEnM = 1'b1;
        addrM   = 16'h0050;
        nextCycle();
        nextCycle();
        @(negedge clk);
        chk("wait dstall", {15'd0, dstall}, 16'h1);
        nextCycle();
        doReset("midrst");
        memAck   = 1'b1;
        memRData = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late ack done",   {15'd0, done},   16'h0);
            chk("late ack dstall", {15'd0, dstall}, 16'h0);
            chk("late ack memReq", {15'd0, memReq}, 16'h0);
            nextCycle();
        end
        memAck = 1'b0;
        $display("txn reset-mid-access done");

`ifdef MEM_TIMEOUT_EN
        // Load with no ack aborts after TIMEOUT=4 cycles
        readEnM = 1'b1;
        addrM   = 16'h0060;
        @(negedge clk);
        chk("to c0 dstall", {15'd0, dstall}, 16'h1);
        nextCycle();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("to dstall",   {15'd0, dstall}, {15'd0, c <= 4});
            chk("to err",      {15'd0, err},    {15'd0, c == 5});
            chk("to done",     {15'd0, done},   16'h0);
            if (c == 5) chk("to dataOutM", dataOutM, 16'h0);
            nextCycle();
        end
        readEnM   = 1'b0;
        modelData = 16'h0;
        lastAddr  = 16'h0060;
        lastWData = wrtDataM;
        $display("txn timeout abort done");
`else
        // Without the watchdog an unanswered load stalls indefinitely
        readEnM = 1'b1;
        addrM   = 16'h0060;
        stallHigh = 0;
        doneSeen  = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dstall === 1'b1) stallHigh++;
            if (done !== 1'b0 || err !== 1'b0) doneSeen++;
            nextCycle();
        end
        chk("noack stall cycles", 16'(stallHigh), 16'd100);
        chk("noack done/err",     16'(doneSeen),  16'd0);
        doReset("noack rst");
        $display("txn no-ack stall of 100 cycles done");
`endif

        // Randomized accesses against the timeline model
        for (int t = 0; t < 200; t++) begin
            kindR  = $urandom_range(0, 3);
            addrR  = 16'($urandom) & 16'hFFFE;
            wdataR = 16'($urandom);
            rdataR = 16'($urandom);
            kR     = $urandom_range(0, 6);
            gapR   = $urandom_range(0, 3);
            rdR    = (kindR == 0) || (kindR == 2);
            wrR    = (kindR == 1) || (kindR == 2);
            if (kindR == 3) begin
                rdR   = 1'($urandom_range(0, 1));
                wrR   = ~rdR;
                addrR = addrR | 16'h0001;
            end
            legalR = (rdR ^ wrR) && !addrR[0];
            expR   = (legalR && rdR) ? rdataR : modelData;
            idleCycles(gapR, 1'b1);
            runAccess(rdR, wrR, addrR, wdataR, rdataR, kR, !legalR, expR);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
